ped_crossing_fsm: RTL and testbench

// - Pedestrian-crossing light controller; downstream consumer of the 2-second tick timer.
// - Counts incoming ticks to time each light phase and serves latched pedestrian requests.
// - Drives the car and pedestrian lamps, plus a maintenance flashing-yellow mode.
// - Pulses timer_clr on every phase change, so the upstream timer restarts aligned to phase start.

---
 rtl/ped_crossing_if.sv | 26 ++
 rtl/ped_crossing_fsm.sv | 180 ++++++++++++++++++
 tb/tb_ped_crossing_fsm.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ped_crossing_if.sv
// Signal bundle between the pedestrian-crossing controller and its environment.
// The master side drives the tick, button and maintenance inputs.
// The slave side (the controller) drives the lamps, the status outputs and the timer restart pulse.
interface ped_crossing_if;
  logic       tick;
  logic       ped_req;
  logic       maint;
  logic       car_g;
  logic       car_y;
  logic       car_r;
  logic       ped_g;
  logic       ped_r;
  logic       req_pending;
  logic       timer_clr;
  logic [2:0] state;

  modport master (
    output tick, ped_req, maint,
    input  car_g, car_y, car_r, ped_g, ped_r, req_pending, timer_clr, state
  );

  modport slave (
    input  tick, ped_req, maint,
    output car_g, car_y, car_r, ped_g, ped_r, req_pending, timer_clr, state
  );
endinterface

// File: rtl/ped_crossing_fsm.sv
// Pedestrian-crossing light controller.
// It times each phase by counting ticks from the upstream 2 s timer and serves latched pedestrian requests.
// It also provides a maintenance flashing-yellow mode.
// All outputs are registered. The lamp values are computed from the next state.
module ped_crossing_fsm #(
  parameter int GREEN_MIN = 5,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 4,
  parameter int FLASH_T   = 3,
  parameter int CNT_W     = 4
) (
  input  logic          clk,
  input  logic          reset,
  ped_crossing_if.slave bus
);

  typedef enum logic [2:0] {
    S_GREEN  = 3'd0,
    S_YELLOW = 3'd1,
    S_ALLRED = 3'd2,
    S_WALK   = 3'd3,
    S_FLASH  = 3'd4,
    S_MAINT  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_T - 1);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc, w_last;
  logic             r_req, w_req_next;
  logic             r_clr, w_clr_next;
  logic             r_car_g, r_car_y, r_car_r, r_ped_g, r_ped_r;
  logic             w_car_g, w_car_y, w_car_r, w_ped_g, w_ped_r;
  logic             w_done;

  // Last count value of the current timed phase
  always_comb begin
    w_last = GREEN_LAST;
    case (r_state)
      S_YELLOW: w_last = YELLOW_LAST;
      S_ALLRED: w_last = ALLRED_LAST;
      S_WALK:   w_last = WALK_LAST;
      S_FLASH:  w_last = FLASH_LAST;
      default:  w_last = GREEN_LAST;
    endcase
  end

  assign w_done    = bus.tick && (r_cnt == w_last);
  assign w_cnt_inc = r_cnt + 1'b1;

  // Next phase, tick counter and request latch; maintenance overrides everything
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_req_next   = r_req;
    if (bus.maint) begin
      w_state_next = S_MAINT;
      w_cnt_next   = '0;
      w_req_next   = 1'b0;
    end else begin
      case (r_state)
        S_GREEN: begin
          // The exit decision uses the already-latched request, not this cycle's button press.
          w_req_next = r_req | bus.ped_req;
          if (bus.tick) begin
            if (r_cnt != GREEN_LAST) begin
              w_cnt_next = w_cnt_inc;
            end else if (r_req) begin
              w_state_next = S_YELLOW;
              w_cnt_next   = '0;
            end
          end
        end
        S_YELLOW: begin
          w_req_next = r_req | bus.ped_req;
          if (w_done) begin
            w_state_next = S_ALLRED;
            w_cnt_next   = '0;
          end else if (bus.tick) begin
            w_cnt_next = w_cnt_inc;
          end
        end
        S_ALLRED: begin
          w_req_next = r_req | bus.ped_req;
          if (w_done) begin
            // The request is served here, so clearing it wins over a simultaneous press.
            w_state_next = S_WALK;
            w_cnt_next   = '0;
            w_req_next   = 1'b0;
          end else if (bus.tick) begin
            w_cnt_next = w_cnt_inc;
          end
        end
        S_WALK: begin
          if (w_done) begin
            w_state_next = S_FLASH;
            w_cnt_next   = '0;
          end else if (bus.tick) begin
            w_cnt_next = w_cnt_inc;
          end
        end
        S_FLASH: begin
          if (w_done) begin
            w_state_next = S_GREEN;
            w_cnt_next   = '0;
          end else if (bus.tick) begin
            w_cnt_next = w_cnt_inc;
          end
        end
        default: begin
          // Leaving maintenance, or recovering from an illegal code
          w_state_next = S_GREEN;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // Lamp values for the next state; blinking lamps start lit on entry and toggle per tick
  always_comb begin
    w_car_g    = 1'b0;
    w_car_y    = 1'b0;
    w_car_r    = 1'b0;
    w_ped_g    = 1'b0;
    w_ped_r    = 1'b0;
    w_clr_next = (w_state_next != r_state);
    case (w_state_next)
      S_GREEN:  begin w_car_g = 1'b1; w_ped_r = 1'b1; end
      S_YELLOW: begin w_car_y = 1'b1; w_ped_r = 1'b1; end
      S_ALLRED: begin w_car_r = 1'b1; w_ped_r = 1'b1; end
      S_WALK:   begin w_car_r = 1'b1; w_ped_g = 1'b1; end
      S_FLASH: begin
        w_car_r = 1'b1;
        w_ped_g = w_clr_next ? 1'b1 : (r_ped_g ^ bus.tick);
      end
      S_MAINT: w_car_y = w_clr_next ? 1'b1 : (r_car_y ^ bus.tick);
      default: begin w_car_g = 1'b1; w_ped_r = 1'b1; end
    endcase
  end

  // State, counter, request and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_GREEN;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_clr   <= 1'b0;
      r_car_g <= 1'b1;
      r_car_y <= 1'b0;
      r_car_r <= 1'b0;
      r_ped_g <= 1'b0;
      r_ped_r <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_req   <= w_req_next;
      r_clr   <= w_clr_next;
      r_car_g <= w_car_g;
      r_car_y <= w_car_y;
      r_car_r <= w_car_r;
      r_ped_g <= w_ped_g;
      r_ped_r <= w_ped_r;
    end
  end

  assign bus.state       = r_state;
  assign bus.car_g       = r_car_g;
  assign bus.car_y       = r_car_y;
  assign bus.car_r       = r_car_r;
  assign bus.ped_g       = r_ped_g;
  assign bus.ped_r       = r_ped_r;
  assign bus.req_pending = r_req;
  assign bus.timer_clr   = r_clr;

endmodule

// File: tb/tb_ped_crossing_fsm.sv
// Testbench for ped_crossing_fsm.
// Directed scenarios and a randomized run are compared every cycle against a phase/elapsed-tick reference model.
module tb_ped_crossing_fsm;
  localparam int GREEN_MIN = 5;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
  localparam int WALK_T    = 4;
  localparam int FLASH_T   = 3;
  localparam logic [9:0] RESET_VEC = 10'b000_10001_0_0;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  ped_crossing_if bus();

  ped_crossing_fsm #(
    .GREEN_MIN(GREEN_MIN), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T),
    .WALK_T(WALK_T), .FLASH_T(FLASH_T), .CNT_W(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int clr_count = 0;

  // Reference model: phase number, ticks elapsed in phase, request latch, blink lamp, restart pulse
  int m_phase = 0;
  int m_n     = 0;
  bit m_req   = 0;
  bit m_blink = 0;
  bit m_clr   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", tag, act, exp);
    end
  endtask

  function automatic int dur_of(input int p);
    case (p)
      1:       return YELLOW_T;
      2:       return ALLRED_T;
      3:       return WALK_T;
      4:       return FLASH_T;
      default: return GREEN_MIN;
    endcase
  endfunction

  function automatic logic [9:0] model_outs();
    logic [4:0] lamps;  // car_g car_y car_r ped_g ped_r
    case (m_phase)
      0:       lamps = 5'b10001;
      1:       lamps = 5'b01001;
      2:       lamps = 5'b00101;
      3:       lamps = 5'b00110;
      4:       lamps = {3'b001, m_blink, 1'b0};
      default: lamps = {1'b0, m_blink, 3'b000};
    endcase
    return {3'(m_phase), lamps, m_req, m_clr};
  endfunction

  function automatic logic [9:0] dut_outs();
    return {bus.state, bus.car_g, bus.car_y, bus.car_r, bus.ped_g, bus.ped_r,
            bus.req_pending, bus.timer_clr};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_req = 0; m_blink = 0; m_clr = 0;
  endtask

  task automatic model_step(input bit t, input bit p, input bit m);
    int old;
    bit req_new;
    old = m_phase;
    req_new = m_req;
    if (m) begin
      m_phase = 5; m_n = 0; req_new = 0;
      m_blink = (old == 5) ? (m_blink ^ t) : 1'b1;
    end else if (old == 5) begin
      m_phase = 0; m_n = 0;
    end else begin
      if (old <= 2) req_new = m_req | p;
      if (t) begin
        if (old == 0) begin
          // Green lasts at least GREEN_MIN ticks and ends only with a request already latched
          if (m_n + 1 >= GREEN_MIN && m_req) begin m_phase = 1; m_n = 0; end
          else m_n++;
        end else if (m_n + 1 == dur_of(old)) begin
          m_phase = (old == 4) ? 0 : old + 1;
          m_n = 0;
          if (m_phase == 3) req_new = 0;
          if (m_phase == 4) m_blink = 1'b1;
        end else begin
          m_n++;
          if (old == 4) m_blink = ~m_blink;
        end
      end
    end
    m_req = req_new;
    m_clr = (m_phase != old);
  endtask

  // One clock cycle: apply inputs, clock, step the model, compare all outputs
  task automatic cycle(input bit t, input bit p, input bit m);
    bus.tick = t; bus.ped_req = p; bus.maint = m;
    @(posedge clk);
    model_step(t, p, m);
    #1;
    cyc++;
    check_eq($sformatf("outs@%0d", cyc), 32'(dut_outs()), 32'(model_outs()));
    if (bus.timer_clr === 1'b1) clr_count++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.tick = 0; bus.ped_req = 0; bus.maint = 0;
    model_reset();
    #2;
    check_eq("reset_vals", 32'(dut_outs()), 32'(RESET_VEC));
    @(negedge clk);
    reset = 1'b1;
    clr_count = 0;
  endtask

  // Ticks every other cycle until the model reaches the phase, bounded
  task automatic tick_until(input int phase, input bit p);
    int k = 0;
    while (m_phase != phase && k < 60) begin
      cycle(0, p, 0);
      cycle(1, p, 0);
      k++;
    end
    check_eq($sformatf("reach_phase%0d", phase), 32'(bus.state), 32'(phase));
  endtask

  initial begin
    bus.tick = 0; bus.ped_req = 0; bus.maint = 0;

    // Idle: 20 ticks with no request
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0);
      cycle(1, 0, 0);
    end
    check_eq("idle_state", 32'(bus.state), 32'd0);
    check_eq("idle_clr", 32'(clr_count), 32'd0);
    $display("scenario idle: cycles=%0d clr_pulses=%0d", cyc, clr_count);

    // One pedestrian request before the first tick: full crossing cycle
    do_reset();
    begin
      int tk = 0, exit_tick = 0, fn = 0;
      bit left = 0, req_allred = 0, req_walk = 1, seen_walk = 0;
      logic [2:0] fseq = 3'b000;
      cycle(0, 1, 0);
      for (int i = 0; i < 40; i++) begin
        cycle(1, 0, 0);
        tk++;
        if (bus.state == 3'd1 && exit_tick == 0) exit_tick = tk;
        if (bus.state == 3'd2) req_allred = bus.req_pending;
        if (bus.state == 3'd3 && !seen_walk) begin seen_walk = 1; req_walk = bus.req_pending; end
        if (bus.state == 3'd4) begin fseq = {fseq[1:0], bus.ped_g}; fn++; end
        if (bus.state != 3'd0) left = 1;
        if (left && bus.state == 3'd0) break;
        cycle(0, 0, 0);
      end
      check_eq("green_exit_tick", 32'(exit_tick), 32'd5);
      check_eq("cycle_ticks", 32'(tk), 32'd15);
      check_eq("flash_seq", 32'(fseq), 32'b101);
      check_eq("flash_len", 32'(fn), 32'd3);
      check_eq("req_at_allred", 32'(req_allred), 32'd1);
      check_eq("req_at_walk", 32'(req_walk), 32'd0);
      check_eq("cycle_clr", 32'(clr_count), 32'd5);
      $display("scenario crossing: ticks=%0d exit_tick=%0d clr_pulses=%0d", tk, exit_tick, clr_count);
    end

    // Request on the 10th tick leaves green on the 11th; button then held through walk/flash
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 0);
      cycle(1, 0, 0);
    end
    cycle(0, 0, 0);
    cycle(1, 1, 0);
    check_eq("req10_still_green", 32'(bus.state), 32'd0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    check_eq("req11_yellow", 32'(bus.state), 32'd1);
    tick_until(4, 1'b1);
    tick_until(0, 1'b1);
    check_eq("held_req_clear", 32'(bus.req_pending), 32'd0);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0);
      cycle(1, 0, 0);
    end
    check_eq("no_second_cycle", 32'(bus.state), 32'd0);
    $display("scenario held_request: state=%0d req=%0d", bus.state, bus.req_pending);

    // Maintenance entered mid-walk, then released
    do_reset();
    cycle(0, 1, 0);
    tick_until(3, 1'b0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 1);
    check_eq("maint_state", 32'(bus.state), 32'd5);
    check_eq("maint_lamps", 32'({bus.car_g, bus.car_y, bus.car_r, bus.ped_g, bus.ped_r}), 32'b01000);
    cycle(1, 0, 1);
    check_eq("maint_blink0", 32'(bus.car_y), 32'd0);
    cycle(1, 0, 1);
    check_eq("maint_blink1", 32'(bus.car_y), 32'd1);
    clr_count = 0;
    cycle(0, 0, 0);
    check_eq("maint_exit_state", 32'(bus.state), 32'd0);
    begin
      int tk = 0;
      cycle(0, 1, 0);
      while (bus.state == 3'd0 && tk < 20) begin
        cycle(1, 0, 0);
        tk++;
        if (bus.state == 3'd0) cycle(0, 0, 0);
      end
      check_eq("maint_exit_cnt0", 32'(tk), 32'(GREEN_MIN));
    end
    check_eq("maint_exit_clr", 32'(clr_count), 32'd2);
    $display("scenario maint: exit_clr_and_yellow_clr=%0d", clr_count);

    // Asynchronous reset between clock edges during yellow
    do_reset();
    cycle(0, 1, 0);
    tick_until(1, 1'b0);
    cycle(0, 0, 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_reset", 32'(dut_outs()), 32'(RESET_VEC));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    $display("scenario async_reset: outs=0x%0h", dut_outs());

    // Randomized traffic against the model
    begin
      bit m = 0;
      for (int i = 0; i < 3000; i++) begin
        if (m) m = ($urandom_range(0, 5) != 0);
        else   m = ($urandom_range(0, 79) == 0);
        cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), m);
      end
      $display("scenario random: cycles=3000 failures_so_far=%0d", failures);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
